// File: rtl/sw_pkg.sv
// Shared defaults and address-width helper for the search-window column buffer.
package sw_pkg;

  localparam int DEF_PIX_W    = 8;
  localparam int DEF_WR_LANES = 4;
  localparam int DEF_NUM_COLS = 4;
  localparam int DEF_COL_H    = 88;

  function automatic int addrW(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sw_col_map.sv
// Logical-to-physical address rotation: (lcol + baseCol) mod NUM_COLS, offset kept.
module sw_col_map
  import sw_pkg::*;
#(
  parameter int NUM_COLS = DEF_NUM_COLS,
  parameter int UNIT     = DEF_COL_H,
  parameter int AW       = addrW(NUM_COLS * UNIT)
) (
  input  logic [AW-1:0]                logAddr,
  input  logic [addrW(NUM_COLS)-1:0]   baseCol,
  output logic [AW-1:0]                physAddr,
  output logic                         inRange
);

  localparam int CW = addrW(NUM_COLS);

  logic [AW-1:0] lcol;
  logic [AW-1:0] offset;
  logic [CW-1:0] pcol;

  assign lcol     = logAddr / AW'(UNIT);
  assign offset   = logAddr % AW'(UNIT);
  assign inRange  = lcol < AW'(NUM_COLS);
  // NUM_COLS is a power of two, so truncating the sum wraps the column index
  assign pcol     = lcol[CW-1:0] + baseCol;
  assign physAddr = AW'(pcol) * AW'(UNIT) + offset;

endmodule

// File: rtl/sw_col_buf.sv
// Rotating search-window column buffer: wide word writes, single-pixel reads, per-column fill tracking.
module sw_col_buf
  import sw_pkg::*;
#(
  parameter int PIX_W    = DEF_PIX_W,
  parameter int WR_LANES = DEF_WR_LANES,
  parameter int NUM_COLS = DEF_NUM_COLS,
  parameter int COL_H    = DEF_COL_H
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic                                        wr_en,
  input  logic [addrW(NUM_COLS*(COL_H/WR_LANES))-1:0] wr_addr,
  input  logic [WR_LANES*PIX_W-1:0]                   wr_data,
  input  logic                                        rd_en,
  input  logic [addrW(NUM_COLS*COL_H)-1:0]            rd_addr,
  input  logic                                        rotate,
  output logic [PIX_W-1:0]                            rd_data,
  output logic                                        rd_valid,
  output logic [addrW(NUM_COLS)-1:0]                  base_col,
  output logic [NUM_COLS-1:0]                         col_ready,
  output logic                                        win_ready
);

  localparam int WPC = COL_H / WR_LANES;
  localparam int NW  = NUM_COLS * WPC;
  localparam int NP  = NUM_COLS * COL_H;
  localparam int DW  = WR_LANES * PIX_W;
  localparam int WAW = addrW(NW);
  localparam int RAW = addrW(NP);
  localparam int CW  = addrW(NUM_COLS);
  localparam int LW  = addrW(WR_LANES);
  localparam logic [NW-1:0] COL_MASK = NW'({WPC{1'b1}});

  logic [DW-1:0]  mem [NW];
  logic [NW-1:0]  written;
  logic [WAW-1:0] wrPhys;
  logic           wrInRange;
  logic           wrOk;
  logic [RAW-1:0] rdPhys;
  logic           rdInRange;
  logic [WAW-1:0] rdWordIdx;
  logic [LW-1:0]  rdLane;
  logic [DW-1:0]  rdWord;
  logic [PIX_W-1:0] rdPixel;
  logic [NW-1:0]  setMask;
  logic [NW-1:0]  clearMask;

  sw_col_map #(.NUM_COLS(NUM_COLS), .UNIT(WPC), .AW(WAW)) uWrMap (
    .logAddr (wr_addr),
    .baseCol (base_col),
    .physAddr(wrPhys),
    .inRange (wrInRange)
  );

  sw_col_map #(.NUM_COLS(NUM_COLS), .UNIT(COL_H), .AW(RAW)) uRdMap (
    .logAddr (rd_addr),
    .baseCol (base_col),
    .physAddr(rdPhys),
    .inRange (rdInRange)
  );

  assign wrOk      = wr_en && wrInRange;
  assign rdWordIdx = WAW'(rdPhys / RAW'(WR_LANES));
  assign rdLane    = LW'(rdPhys % RAW'(WR_LANES));
  // forward a same-cycle write so the read sees the new word
  assign rdWord    = (wrOk && (wrPhys == rdWordIdx)) ? wr_data : mem[rdWordIdx];
  assign rdPixel   = PIX_W'(rdWord >> (rdLane * PIX_W));

  assign setMask   = wrOk ? (NW'(1) << wrPhys) : '0;
  assign clearMask = rotate ? (COL_MASK << (base_col * WPC)) : '0;

  always_ff @(posedge clk) begin
    if (wrOk) mem[wrPhys] <= wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      base_col <= '0;
      written  <= '0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) rd_data <= rdInRange ? rdPixel : '0;
      // clear applied after set: a write into the retiring column stays unmarked
      written <= (written | setMask) & ~clearMask;
      if (rotate) base_col <= base_col + 1'b1;
    end
  end

  for (genvar i = 0; i < NUM_COLS; i++) begin : gReady
    logic [CW-1:0]  pc;
    logic [WPC-1:0] colBits;
    assign pc           = CW'(i) + base_col;
    assign colBits      = WPC'(written >> (pc * WPC));
    assign col_ready[i] = &colBits;
  end

  assign win_ready = &col_ready;

endmodule

// File: tb/tb_sw_col_buf.sv
// Scoreboard bench for sw_col_buf: reads are predicted by a physical-pixel model and checked on rd_valid.
module tb_sw_col_buf;

  logic        clk;
  logic        rst;
  logic        wr_en;
  logic [6:0]  wr_addr;
  logic [31:0] wr_data;
  logic        rd_en;
  logic [8:0]  rd_addr;
  logic        rotate;
  logic [7:0]  rd_data;
  logic        rd_valid;
  logic [1:0]  base_col;
  logic [3:0]  col_ready;
  logic        win_ready;

  int checks   = 0;
  int failures = 0;

  logic [7:0] expQ [$];
  logic [7:0] pix [352];
  bit         wb [4][22];
  int         mBase = 0;

  sw_col_buf #(.PIX_W(8), .WR_LANES(4), .NUM_COLS(4), .COL_H(88)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr), .rotate(rotate), .rd_data(rd_data),
    .rd_valid(rd_valid), .base_col(base_col), .col_ready(col_ready), .win_ready(win_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rd_valid) begin
      logic [7:0] e;
      checks++;
      if (expQ.size() == 0) begin
        failures++;
        $display("FAIL unexpected_rd_valid: got rd_valid=1 rd_data=%0h required no read pending", rd_data);
      end else begin
        e = expQ.pop_front();
        if (rd_data !== e) begin
          failures++;
          $display("FAIL scoreboard_rd_data: got %0h required %0h", rd_data, e);
        end
      end
    end
  end

  function automatic logic [3:0] expReady();
    logic [3:0] r;
    for (int i = 0; i < 4; i++) begin
      r[i] = 1'b1;
      for (int j = 0; j < 22; j++) if (!wb[(i + mBase) % 4][j]) r[i] = 1'b0;
    end
    return r;
  endfunction

  function automatic logic [31:0] fillWord(input int a);
    logic [31:0] w;
    for (int k = 0; k < 4; k++) w[k*8 +: 8] = 8'(a * 4 + k);
    return w;
  endfunction

  // one clock of stimulus; the model applies write, then read, then rotate with the pre-rotate base
  task automatic step(input logic we, input int wa, input logic [31:0] wd,
                      input logic re, input int ra, input logic rot);
    int pc;
    wr_en = we; wr_addr = 7'(wa); wr_data = wd;
    rd_en = re; rd_addr = 9'(ra); rotate = rot;
    if (we && wa < 88) begin
      pc = ((wa / 22) + mBase) % 4;
      for (int k = 0; k < 4; k++) pix[pc*88 + (wa % 22)*4 + k] = wd[k*8 +: 8];
      wb[pc][wa % 22] = 1'b1;
    end
    if (re) begin
      if (ra < 352) expQ.push_back(pix[(((ra / 88) + mBase) % 4)*88 + ra % 88]);
      else expQ.push_back(8'h00);
    end
    if (rot) begin
      for (int j = 0; j < 22; j++) wb[mBase][j] = 1'b0;
      mBase = (mBase + 1) % 4;
    end
    @(posedge clk);
    #1;
    wr_en = 1'b0; rd_en = 1'b0; rotate = 1'b0;
  endtask

  task automatic test_reset();
    checks++;
    if (base_col !== 2'd0 || col_ready !== 4'b0 || win_ready !== 1'b0 ||
        rd_valid !== 1'b0 || rd_data !== 8'h00) begin
      failures++;
      $display("FAIL reset_state: got base=%0d ready=%b win=%b vld=%b data=%0h required 0 0000 0 0 00",
               base_col, col_ready, win_ready, rd_valid, rd_data);
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_fill();
    for (int a = 0; a < 88; a++) begin
      step(1'b1, a, fillWord(a), 1'b0, 0, 1'b0);
      if (a == 86) begin
        checks++;
        if (col_ready !== 4'b0111 || win_ready !== 1'b0) begin
          failures++;
          $display("FAIL fill_almost: got ready=%b win=%b required 0111 0", col_ready, win_ready);
        end
      end
    end
    checks++;
    if (win_ready !== 1'b1 || col_ready !== 4'b1111) begin
      failures++;
      $display("FAIL fill_done: got ready=%b win=%b required 1111 1", col_ready, win_ready);
    end
    step(1'b0, 0, '0, 1'b1, 5, 1'b0);
    checks++;
    if (rd_valid !== 1'b1 || rd_data !== 8'h05) begin
      failures++;
      $display("FAIL fill_read5: got vld=%b data=%0h required 1 05", rd_valid, rd_data);
    end
    step(1'b0, 0, '0, 1'b1, 351, 1'b0);
    step(1'b0, 0, '0, 1'b1, 170, 1'b0);
  endtask

  task automatic test_rotate();
    step(1'b0, 0, '0, 1'b0, 0, 1'b1);
    checks++;
    if (base_col !== 2'd1 || col_ready !== 4'b0111 || win_ready !== 1'b0) begin
      failures++;
      $display("FAIL rotate_state: got base=%0d ready=%b win=%b required 1 0111 0",
               base_col, col_ready, win_ready);
    end
    step(1'b0, 0, '0, 1'b1, 0, 1'b0);
    checks++;
    if (rd_data !== 8'h58) begin
      failures++;
      $display("FAIL rotate_read0: got %0h required 58", rd_data);
    end
  endtask

  task automatic test_wrap();
    step(1'b1, 66, 32'hDDCCBBAA, 1'b0, 0, 1'b0);
    step(1'b0, 0, '0, 1'b1, 264, 1'b0);
    checks++;
    if (rd_data !== 8'hAA || col_ready !== 4'b0111) begin
      failures++;
      $display("FAIL wrap_write66: got data=%0h ready=%b required aa 0111", rd_data, col_ready);
    end
    for (int r = 0; r < 3; r++) step(1'b0, 0, '0, 1'b0, 0, 1'b1);
    checks++;
    if (base_col !== 2'd0 || col_ready !== 4'b0000) begin
      failures++;
      $display("FAIL wrap_base: got base=%0d ready=%b required 0 0000", base_col, col_ready);
    end
    step(1'b0, 0, '0, 1'b1, 0, 1'b0);
    checks++;
    if (rd_data !== 8'hAA) begin
      failures++;
      $display("FAIL wrap_phys0: got %0h required aa", rd_data);
    end
  endtask

  task automatic test_collision();
    for (int a = 0; a < 88; a++) step(1'b1, a, fillWord(a), 1'b0, 0, 1'b0);
    step(1'b1, 1, 32'h11223344, 1'b0, 0, 1'b1);
    step(1'b0, 0, '0, 1'b1, 268, 1'b0);
    checks++;
    if (rd_data !== 8'h44 || base_col !== 2'd1) begin
      failures++;
      $display("FAIL rot_write_data: got data=%0h base=%0d required 44 1", rd_data, base_col);
    end
    for (int r = 0; r < 22; r++) if (r != 1) step(1'b1, 66 + r, fillWord(r), 1'b0, 0, 1'b0);
    checks++;
    if (col_ready !== 4'b0111) begin
      failures++;
      $display("FAIL rot_write_bits: got ready=%b required 0111", col_ready);
    end
    step(1'b1, 67, 32'h11223344, 1'b0, 0, 1'b0);
    checks++;
    if (col_ready !== 4'b1111 || win_ready !== 1'b1) begin
      failures++;
      $display("FAIL rot_write_refill: got ready=%b win=%b required 1111 1", col_ready, win_ready);
    end
    step(1'b1, 2, 32'h00AB0000, 1'b1, 10, 1'b0);
    checks++;
    if (rd_data !== 8'hAB) begin
      failures++;
      $display("FAIL same_cycle_rw: got %0h required ab", rd_data);
    end
  endtask

  task automatic test_bounds();
    logic [7:0] held;
    step(1'b1, 88, 32'hFFFFFFFF, 1'b0, 0, 1'b0);
    checks++;
    if (col_ready !== expReady() || col_ready !== 4'b1111) begin
      failures++;
      $display("FAIL wr_out_of_range: got ready=%b required 1111", col_ready);
    end
    step(1'b0, 0, '0, 1'b1, 5, 1'b0);
    held = rd_data;
    step(1'b0, 0, '0, 1'b0, 0, 1'b0);
    step(1'b0, 0, '0, 1'b0, 0, 1'b0);
    checks++;
    if (rd_valid !== 1'b0 || rd_data !== held || held !== 8'h5D) begin
      failures++;
      $display("FAIL rd_hold: got vld=%b data=%0h required 0 5d", rd_valid, rd_data);
    end
    step(1'b0, 0, '0, 1'b1, 352, 1'b0);
    checks++;
    if (rd_valid !== 1'b1 || rd_data !== 8'h00) begin
      failures++;
      $display("FAIL rd_out_of_range: got vld=%b data=%0h required 1 00", rd_valid, rd_data);
    end
  endtask

  task automatic test_back_to_back();
    for (int n = 0; n < 40; n++) begin
      step($urandom_range(0, 1) == 1, int'($urandom_range(0, 95)), $urandom,
           $urandom_range(0, 3) != 0, int'($urandom_range(0, 359)), $urandom_range(0, 7) == 0);
      checks++;
      if (col_ready !== expReady() || base_col !== 2'(mBase)) begin
        failures++;
        $display("FAIL b2b_state: got ready=%b base=%0d required %b %0d",
                 col_ready, base_col, expReady(), mBase);
      end
    end
  endtask

  task automatic test_reset_midop();
    step(1'b0, 0, '0, 1'b0, 0, 1'b1);
    rd_en = 1'b1; rd_addr = 9'd5; rst = 1'b1;
    @(posedge clk); #1;
    rd_en = 1'b0;
    checks++;
    if (rd_valid !== 1'b0 || base_col !== 2'd0 || rd_data !== 8'h00 || col_ready !== 4'b0000) begin
      failures++;
      $display("FAIL reset_midop: got vld=%b base=%0d data=%0h ready=%b required 0 0 00 0000",
               rd_valid, base_col, rd_data, col_ready);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    mBase = 0;
    for (int c = 0; c < 4; c++) for (int j = 0; j < 22; j++) wb[c][j] = 1'b0;
    step(1'b0, 0, '0, 1'b1, 5, 1'b0);
    step(1'b0, 0, '0, 1'b1, 200, 1'b0);
  endtask

  task automatic test_drain();
    int n = 0;
    while (expQ.size() != 0 && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (expQ.size() != 0) begin
      failures++;
      $display("FAIL drain_timeout: got %0d reads outstanding required 0", expQ.size());
    end
  endtask

  initial begin
    rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    rd_en = 1'b0; rd_addr = '0; rotate = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_fill();
    test_rotate();
    test_wrap();
    test_collision();
    test_bounds();
    test_back_to_back();
    test_reset_midop();
    test_drain();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sw_col_buf.md
SW_COL_BUF -- requirements
Module: sw_col_buf

Interface
REQ-001 SHALL have parameter PIX_W, default 8, pixel width in bits.
REQ-002 SHALL have parameter WR_LANES, default 4, pixels per write word.
REQ-003 SHALL have parameter NUM_COLS, default 4, search-window columns held (power of two).
REQ-004 SHALL have parameter COL_H, default 88, pixels per column (multiple of WR_LANES); WPC = COL_H/WR_LANES words per column.
REQ-005 SHALL have port clk  in  1  single clock, all state on rising edge.
REQ-006 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-007 SHALL have port wr_en  in  1  write strobe.
REQ-008 SHALL have port wr_addr  in  clog2(NUM_COLS*WPC)  logical word address = lcol*WPC + wrow.
REQ-009 SHALL have port wr_data  in  WR_LANES*PIX_W  lane k (bits k*PIX_W+:PIX_W) goes to pixel wrow*WR_LANES+k.
REQ-010 SHALL have port rd_en  in  1  read request.
REQ-011 SHALL have port rd_addr  in  clog2(NUM_COLS*COL_H)  logical pixel address = lcol*COL_H + row.
REQ-012 SHALL have port rotate  in  1  retire logical column 0, shift window one column.
REQ-013 SHALL have port rd_data  out  PIX_W  pixel from last accepted read.
REQ-014 SHALL have port rd_valid  out  1  one-cycle pulse, rd_data updated.
REQ-015 SHALL have port base_col  out  clog2(NUM_COLS)  physical column mapped to logical column 0.
REQ-016 SHALL have port col_ready  out  NUM_COLS  bit i = logical column i fully written.
REQ-017 SHALL have port win_ready  out  1  AND of col_ready.

Function
REQ-018 SHALL map logical column lcol to physical column (lcol + base_col) mod NUM_COLS for both reads and writes.
REQ-019 SHALL, on wr_en with in-range wr_addr, write all WR_LANES pixels in one cycle and set that physical word's written bit.
REQ-020 SHALL ignore wr_en with wr_addr >= NUM_COLS*WPC: no array change, no written-bit change.
REQ-021 SHALL, on rd_en, capture the physical pixel address; rd_data SHALL show that pixel from the next cycle, rd_valid high that cycle only; latency exactly 1.
REQ-022 SHALL hold rd_data between reads; out-of-range rd_addr SHALL give rd_data = 0 with rd_valid still pulsed.
REQ-023 SHALL, on rotate, set base_col <= (base_col + 1) mod NUM_COLS and clear all WPC written bits of the old base physical column, which becomes logical column NUM_COLS-1.
REQ-024 SHALL set col_ready[i] only when all WPC words of logical column i are written; rewriting a word SHALL NOT double-count.
REQ-025 SHALL, when rotate coincides with wr_en or rd_en, map addresses with the pre-rotate base_col.
REQ-026 SHALL, when rotate and a write to the retiring column coincide, store the data but leave its written bits cleared (rotate wins).
REQ-027 SHALL, for a read and write to the same pixel in one cycle, return the newly written value.
REQ-028 SHALL update col_ready/win_ready combinationally from registered state (valid the cycle after the causing edge).

Reset
REQ-029 SHALL, while rst is high, force base_col = 0, all written bits = 0, rd_valid = 0, rd_data = 0, col_ready = 0, win_ready = 0.
REQ-030 SHALL NOT reset pixel array contents; reset mid-operation SHALL drop any pending read (no rd_valid afterwards).

Structure
REQ-031 SHALL place default parameters and address-width helper functions in shared package sw_pkg.
REQ-032 SHALL implement logical-to-physical mapping in one sub-module sw_col_map, instanced for write and read paths.

Verification
REQ-033 SHALL test fill: write 88 words with wr_data = {4 bytes = addr*4+3..addr*4} -> win_ready after last write; rd_addr 5 returns 0x05.
REQ-034 SHALL test rotate: after full fill, rotate -> base_col = 1, col_ready = 4'b0111, win_ready = 0; rd_addr 0 returns former pixel 88 (0x58).
REQ-035 SHALL test wrap: four rotates from base 0 -> base_col = 0; write logical word 66 after first rotate lands in physical column 0.
REQ-036 SHALL test collisions: rotate with write to logical column 0 -> data stored, bits cleared; same-cycle read/write of pixel 10 with 0xAB -> rd_data = 0xAB next cycle.
REQ-037 SHALL test bounds/reset: wr_addr 88 ignored, rd_addr 352 -> rd_data 0 with rd_valid; rst asserted with rd_en -> rd_valid stays 0, base_col 0.
